// File: rtl/seg_pkg.sv
// Shared constants and the nibble-to-segment encoder for the seven-segment scan driver.
// Segment vectors are active-low, bit6 = a ... bit0 = g.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // Nibbles 10..15 render as letters only in hex mode; otherwise they are blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input logic hex);
    logic [6:0] s;
    case (nibble)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = hex ? SEG_A : SEG_BLANK;
      4'hB:    s = hex ? SEG_B : SEG_BLANK;
      4'hC:    s = hex ? SEG_C : SEG_BLANK;
      4'hD:    s = hex ? SEG_D : SEG_BLANK;
      4'hE:    s = hex ? SEG_E : SEG_BLANK;
      default: s = hex ? SEG_F : SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to seven-segment decoder.
//   nibble_i : 4-bit digit value
//   hex_i    : 1 = show A..F, 0 = blank 10..15
//   seg_o    : active-low segments, bit6 = a ... bit0 = g
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_encode(nibble_i, hex_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment display driver. Scans one digit per SCAN_DIV-clock slot,
// with hex mode, leading-zero blanking, per-digit decimal points and per-digit blink.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : strobe capturing value_i, dp_in_i, blink_mask_i into shadow registers
//   value_i        : DIGITS nibbles, digit 0 in [3:0]
//   dp_in_i        : decimal point request per digit (1 = lit)
//   blink_mask_i   : per-digit blink enable
//   hex_mode_i     : live; 1 = show A..F
//   blank_lz_i     : live; 1 = suppress leading zeros
//   led_in_i/led_o : status LED, one register stage
//   seg_o, dp_o    : active-low segment bus and decimal point
//   an_o           : active-low digit enables
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_in_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
  input  logic                  hex_mode_i,
  input  logic                  blank_lz_i,
  input  logic                  led_in_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  led_o
);

  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PresW  = $clog2(SCAN_DIV);
  localparam int unsigned FrameW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
  localparam logic [PresW-1:0]  PresLast  = PresW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_DIV - 1);

  logic [PresW-1:0]    presc_q, presc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic                blink_q, blink_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dpm_q, dpm_d;
  logic [DIGITS-1:0]   blm_q, blm_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                led_q;

  logic              wrap;
  logic [DIGITS-1:0] lz_mask;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blm, cur_lz, cur_blank;
  logic [6:0]        dec_seg;

  // Prescaler, digit index and blink timebase.
  always_comb begin
    presc_d = presc_q + PresW'(1);
    idx_d   = idx_q;
    wrap    = 1'b0;
    frame_d = frame_q;
    blink_d = blink_q;
    if (presc_q == PresLast) begin
      presc_d = '0;
      if (idx_q == IdxLast) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
    if (wrap) begin
      if (frame_q == FrameLast) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FrameW'(1);
      end
    end
  end

  assign val_d = load_i ? value_i      : val_q;
  assign dpm_d = load_i ? dp_in_i      : dpm_q;
  assign blm_d = load_i ? blink_mask_i : blm_q;

  // A digit is a leading zero when it and every digit to its left are zero; digit 0 never is.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero   = all_zero & (val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero & blank_lz_i;
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_blm = 1'b0;
    cur_lz  = 1'b0;
    an_d    = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib = val_q[4*i +: 4];
        cur_dp  = dpm_q[i];
        cur_blm = blm_q[i];
        cur_lz  = lz_mask[i];
        an_d[i] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (cur_nib),
    .hex_i    (hex_mode_i),
    .seg_o    (dec_seg)
  );

  // Blinked digits keep their enable low but show nothing.
  assign cur_blank = cur_lz | (blink_q & cur_blm);
  assign seg_d     = cur_blank ? SEG_BLANK : dec_seg;
  assign dp_d      = cur_blank ? 1'b1 : ~cur_dp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      val_q   <= '0;
      dpm_q   <= '0;
      blm_q   <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      led_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      val_q   <= val_d;
      dpm_q   <= dpm_d;
      blm_q   <= blm_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      led_q   <= led_in_i;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign an_o  = an_q;
  assign led_o = led_q;

endmodule
